// File: rtl/dffrs_pipe_bank_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dffrs_pipe_pkg : shared types and helpers for dffrs_pipe_bank         |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package dffrs_pipe_pkg;

  // Action applied to every stage on a clock edge, listed in priority order
  typedef enum logic [2:0] {
    ACT_RST   = 3'd0,
    ACT_SCAN  = 3'd1,
    ACT_SET   = 3'd2,
    ACT_SHIFT = 3'd3,
    ACT_HOLD  = 3'd4
  } act_e;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/dffrs_pipe_bank_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dffrs_pipe_bank_if : data/control bundle for dffrs_pipe_bank          |
// | Optional scan pins under DFFRS_PIPE_BANK_SCAN_EN.  Rev 1.0            |
// +----------------------------------------------------------------------+
interface dffrs_pipe_bank_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  import dffrs_pipe_pkg::*;

  localparam int CNT_W = cnt_w(DEPTH);

  logic             SETN;
  logic             EN;
  logic [WIDTH-1:0] D;
  logic             DV;
  logic [WIDTH-1:0] Q;
  logic             QV;
  logic [CNT_W-1:0] FILL;

`ifdef DFFRS_PIPE_BANK_SCAN_EN
  logic SE;
  logic SI;
  logic SO;

  modport master (output SETN, EN, D, DV, SE, SI, input Q, QV, FILL, SO);
  modport slave  (input SETN, EN, D, DV, SE, SI, output Q, QV, FILL, SO);
`else
  modport master (output SETN, EN, D, DV, input Q, QV, FILL);
  modport slave  (input SETN, EN, D, DV, output Q, QV, FILL);
`endif

endinterface
`default_nettype wire

// File: rtl/dffrs_pipe_bank_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dffrs_pipe_stage : one WIDTH-bit settable/resettable stage + valid    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module dffrs_pipe_stage
  import dffrs_pipe_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] SET_VAL = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  act_e             act,
  input  logic [WIDTH-1:0] d_in,
  input  logic             v_in,
  input  logic             scan_in,
  output logic [WIDTH-1:0] q,
  output logic             v
);

  logic [WIDTH-1:0] scan_nxt;

  // Scan enters at bit 0 and leaves from bit WIDTH-1
  if (WIDTH == 1) begin : g_scan_narrow
    assign scan_nxt = scan_in;
  end else begin : g_scan_wide
    assign scan_nxt = {q[WIDTH-2:0], scan_in};
  end

  always_ff @(posedge clk) begin
    case (act)
      ACT_RST: begin
        q <= '0;
        v <= 1'b0;
      end
      ACT_SCAN: q <= scan_nxt;
      ACT_SET: begin
        q <= SET_VAL;
        v <= 1'b0;
      end
      ACT_SHIFT: begin
        q <= d_in;
        v <= v_in;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/dffrs_pipe_bank.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dffrs_pipe_bank : WIDTH x DEPTH flop pipeline with valid + occupancy  |
// | Scan chain under DFFRS_PIPE_BANK_SCAN_EN.  Rev 1.0                    |
// +----------------------------------------------------------------------+
module dffrs_pipe_bank
  import dffrs_pipe_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter int               DEPTH   = 4,
  parameter logic [WIDTH-1:0] SET_VAL = {WIDTH{1'b1}}
) (
  input  logic           CLK,
  input  logic           RST,
  dffrs_pipe_bank_if.slave bus
);

  localparam int CNT_W = cnt_w(DEPTH);

  act_e             act;
  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [DEPTH-1:0] stage_v;
  logic [CNT_W-1:0] fill;
  logic             scan_sel;
  logic             scan_si;

`ifdef DFFRS_PIPE_BANK_SCAN_EN
  assign scan_sel = bus.SE;
  assign scan_si  = bus.SI;
  assign bus.SO   = stage_q[DEPTH-1][WIDTH-1];
`else
  assign scan_sel = 1'b0;
  assign scan_si  = 1'b0;
`endif

  always_comb begin
    act = ACT_HOLD;
    if (RST)            act = ACT_RST;
    else if (scan_sel)  act = ACT_SCAN;
    else if (!bus.SETN) act = ACT_SET;
    else if (bus.EN)    act = ACT_SHIFT;
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic [WIDTH-1:0] d_in;
    logic             v_in;
    logic             s_in;

    if (i == 0) begin : g_head
      assign d_in = bus.D;
      assign v_in = bus.DV;
      assign s_in = scan_si;
    end else begin : g_tail
      assign d_in = stage_q[i-1];
      assign v_in = stage_v[i-1];
      assign s_in = stage_q[i-1][WIDTH-1];
    end

    dffrs_pipe_stage #(
      .WIDTH   (WIDTH),
      .SET_VAL (SET_VAL)
    ) u_stage (
      .clk     (CLK),
      .act     (act),
      .d_in    (d_in),
      .v_in    (v_in),
      .scan_in (s_in),
      .q       (stage_q[i]),
      .v       (stage_v[i])
    );
  end

  // Incremental popcount of stage_v: one word in, one word out per shift
  always_ff @(posedge CLK) begin
    case (act)
      ACT_RST, ACT_SET: fill <= '0;
      ACT_SHIFT:        fill <= fill + CNT_W'(bus.DV) - CNT_W'(stage_v[DEPTH-1]);
      default: ;
    endcase
  end

  assign bus.Q    = stage_q[DEPTH-1];
  assign bus.QV   = stage_v[DEPTH-1];
  assign bus.FILL = fill;

endmodule
`default_nettype wire

// File: tb/tb_dffrs_pipe_bank.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_dffrs_pipe_bank : scoreboard bench for dffrs_pipe_bank             |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_dffrs_pipe_bank;
  import dffrs_pipe_pkg::*;

  localparam int               WIDTH   = 8;
  localparam int               DEPTH   = 4;
  localparam int               NBITS   = WIDTH * DEPTH;
  localparam int               CNT_W   = cnt_w(DEPTH);
  localparam logic [WIDTH-1:0] SET_VAL = 8'hFF;

  typedef struct packed {
    logic [WIDTH-1:0] q;
    logic             qv;
    logic [CNT_W-1:0] fill;
    logic             so;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  dffrs_pipe_bank_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  dffrs_pipe_bank #(
    .WIDTH   (WIDTH),
    .DEPTH   (DEPTH),
    .SET_VAL (SET_VAL)
  ) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  logic [WIDTH-1:0] m_d [DEPTH];
  logic [DEPTH-1:0] m_v;
  exp_t             sb_q [$];
  int               n_checks = 0;
  int               n_errors = 0;
  int               cyc      = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model of one clock edge, in priority order
  task automatic model_edge(input logic r, input logic s, input logic e, input logic se,
                            input logic si, input logic [WIDTH-1:0] d, input logic dv);
    logic [NBITS-1:0] flat;
    if (r) begin
      for (int i = 0; i < DEPTH; i++) m_d[i] = '0;
      m_v = '0;
    end else if (se) begin
      for (int i = 0; i < DEPTH; i++) flat[i*WIDTH +: WIDTH] = m_d[i];
      flat = {flat[NBITS-2:0], si};
      for (int i = 0; i < DEPTH; i++) m_d[i] = flat[i*WIDTH +: WIDTH];
    end else if (!s) begin
      for (int i = 0; i < DEPTH; i++) m_d[i] = SET_VAL;
      m_v = '0;
    end else if (e) begin
      for (int i = DEPTH - 1; i > 0; i--) m_d[i] = m_d[i-1];
      m_d[0] = d;
      m_v    = {m_v[DEPTH-2:0], dv};
    end
  endtask

  task automatic step(input logic r, input logic s, input logic e, input logic [WIDTH-1:0] d,
                      input logic dv, input logic se = 1'b0, input logic si = 1'b0);
    exp_t ex;
    rst      = r;
    bus.SETN = s;
    bus.EN   = e;
    bus.D    = d;
    bus.DV   = dv;
`ifdef DFFRS_PIPE_BANK_SCAN_EN
    bus.SE   = se;
    bus.SI   = si;
`endif
    model_edge(r, s, e, se, si, d, dv);
    ex.q    = m_d[DEPTH-1];
    ex.qv   = m_v[DEPTH-1];
    ex.fill = CNT_W'($countones(m_v));
    ex.so   = m_d[DEPTH-1][WIDTH-1];
    sb_q.push_back(ex);
    @(posedge clk);
    #1;
    cyc++;
    ex = sb_q.pop_front();
    check_val($sformatf("Q@%0d", cyc),    32'(bus.Q),    32'(ex.q));
    check_val($sformatf("QV@%0d", cyc),   32'(bus.QV),   32'(ex.qv));
    check_val($sformatf("FILL@%0d", cyc), 32'(bus.FILL), 32'(ex.fill));
`ifdef DFFRS_PIPE_BANK_SCAN_EN
    check_val($sformatf("SO@%0d", cyc),   32'(bus.SO),   32'(ex.so));
`endif
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] pat;
    logic [WIDTH-1:0] w;
    pat = 32'hDEADBEEF;

    // Reset dominates an active enable/valid
    step(1'b1, 1'b1, 1'b1, 8'hA5, 1'b1);
    step(1'b1, 1'b1, 1'b1, 8'hA5, 1'b1);
    check_val("rst_q", 32'(bus.Q), 32'h0);

    // Continuous stream: first word out on the 4th edge
    for (int v = 1; v <= 5; v++) begin
      w = WIDTH'(v);
      step(1'b0, 1'b1, 1'b1, w, 1'b1);
      if (v == 4) check_val("stream_q4", 32'(bus.Q), 32'h1);
    end

    // Same stream with a two-cycle enable gap after the 2nd word
    step(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b1, 1'b1, 8'h01, 1'b1);
    step(1'b0, 1'b1, 1'b1, 8'h02, 1'b1);
    step(1'b0, 1'b1, 1'b0, 8'h03, 1'b1);
    step(1'b0, 1'b1, 1'b0, 8'h03, 1'b1);
    check_val("gap_fill", 32'(bus.FILL), 32'd2);
    step(1'b0, 1'b1, 1'b1, 8'h03, 1'b1);
    check_val("gap_qv5", 32'(bus.QV), 32'h0);
    step(1'b0, 1'b1, 1'b1, 8'h04, 1'b1);
    check_val("gap_q6", 32'(bus.Q), 32'h1);
    step(1'b0, 1'b1, 1'b1, 8'h05, 1'b1);
    check_val("full_fill", 32'(bus.FILL), 32'd4);

    // Preset beats enable; reset beats preset
    step(1'b0, 1'b0, 1'b1, 8'h77, 1'b1);
    check_val("set_q", 32'(bus.Q), 32'hFF);
    step(1'b1, 1'b0, 1'b1, 8'h77, 1'b1);
    check_val("rst_set_q", 32'(bus.Q), 32'h0);

    // Alternating valid: invalid words still carry data
    for (int i = 0; i < 8; i++) begin
      w = WIDTH'(8'h10 + i);
      step(1'b0, 1'b1, 1'b1, w, ~i[0]);
    end
    check_val("alt_fill", 32'(bus.FILL), 32'd2);

    // Mixed random traffic
    for (int i = 0; i < 150; i++) begin
      step(($urandom_range(0, 19) == 0), ($urandom_range(0, 9) != 0),
           ($urandom_range(0, 3) != 0), WIDTH'($urandom), 1'($urandom));
    end

`ifdef DFFRS_PIPE_BANK_SCAN_EN
    // Leave some valid state so scan can be seen to preserve it
    step(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 8'h5A, 1'b1);
    step(1'b0, 1'b1, 1'b1, 8'h5A, 1'b0);
    for (int i = 0; i < NBITS; i++)
      step(1'b0, 1'($urandom), 1'($urandom), 8'h00, 1'b1, 1'b1, pat[i]);
    for (int i = 0; i < NBITS; i++) begin
      check_val($sformatf("scan_so%0d", i), 32'(bus.SO), 32'(pat[i]));
      step(1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0);
    end
    check_val("scan_fill", 32'(bus.FILL), 32'd3);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
